// File: rtl/demux_rr_ctrl.sv
// Round-robin scheduler that time-shares one 1-to-4 demux among four requesters.
// Optional grant extension via lock is compiled in with `define DEMUX_CTRL_LOCK_EN.
module demux_rr_ctrl #(
    parameter int DWELL = 4,
    parameter int GAP   = 1,
    parameter int CNT_W = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] req,
    input  logic       lock,
    output logic       sel_a,
    output logic       sel_b,
    output logic       en,
    output logic [3:0] gnt,
    output logic       busy
);

    localparam int DWELL_EFF = (DWELL < 1) ? 1 : DWELL;
    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_EFF - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP < 1) ? 0 : GAP - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACTIVE,
        S_GAP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [1:0]       idx_q, idx_d;
    logic             en_q, en_d;
    logic [3:0]       gnt_q, gnt_d;
    logic             busy_q, busy_d;

    logic             pick_valid;
    logic [1:0]       pick_idx;
    logic [1:0]       cand;
    logic             leave;

`ifndef DEMUX_CTRL_LOCK_EN
    logic unused_lock;
    assign unused_lock = lock;
`endif

    // Scan from the farthest offset down so the requester closest to ptr wins.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = ptr_q;
        cand       = 2'd0;
        for (int k = 3; k >= 0; k--) begin
            cand = ptr_q + 2'(k);
            if (req[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ptr_d   = ptr_q;
        idx_d   = idx_q;
        en_d    = 1'b0;
        leave   = 1'b0;
        unique case (state_q)
            S_IDLE: begin
                if (pick_valid) begin
                    idx_d   = pick_idx;
                    cnt_d   = '0;
                    en_d    = 1'b1;
                    state_d = S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (!req[idx_q]) begin
                    leave = 1'b1;
                end else if (cnt_q == DWELL_LAST) begin
`ifdef DEMUX_CTRL_LOCK_EN
                    if (lock) begin
                        cnt_d = '0;
                        en_d  = 1'b1;
                    end else begin
                        leave = 1'b1;
                    end
`else
                    leave = 1'b1;
`endif
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    en_d  = 1'b1;
                end
            end
            S_GAP: begin
                if (cnt_q == GAP_LAST) begin
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        // Normal and early exits both rotate priority past the served index.
        if (leave) begin
            ptr_d   = idx_q + 2'd1;
            cnt_d   = '0;
            state_d = (GAP == 0) ? S_IDLE : S_GAP;
        end

        gnt_d  = en_d ? (4'b0001 << idx_d) : 4'b0000;
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            ptr_q   <= 2'd0;
            idx_q   <= 2'd0;
            en_q    <= 1'b0;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            idx_q   <= idx_d;
            en_q    <= en_d;
            gnt_q   <= gnt_d;
            busy_q  <= busy_d;
        end
    end

    assign sel_a = idx_q[0];
    assign sel_b = idx_q[1];
    assign en    = en_q;
    assign gnt   = gnt_q;
    assign busy  = busy_q;

endmodule

// File: tb/tb_demux_rr_ctrl.sv
// Directed bench for demux_rr_ctrl (DWELL=4, GAP=1) with a grant-order scoreboard.
// Expectations for the lock test follow whether DEMUX_CTRL_LOCK_EN is defined.
module tb_demux_rr_ctrl;

    logic       clk;
    logic       reset;
    logic [3:0] req;
    logic       lock;
    logic       sel_a;
    logic       sel_b;
    logic       en;
    logic [3:0] gnt;
    logic       busy;

    int errors = 0;
    int checks = 0;
    int expQ[$];
    logic       prevEn  = 1'b0;
    logic [1:0] prevSel = 2'd0;

    demux_rr_ctrl #(.DWELL(4), .GAP(1), .CNT_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .req   (req),
        .lock  (lock),
        .sel_a (sel_a),
        .sel_b (sel_b),
        .en    (en),
        .gnt   (gnt),
        .busy  (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [3:0] r, input logic l);
        req  = r;
        lock = l;
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Invariants every cycle, and grant order popped from the scoreboard on each en rise.
    always @(negedge clk) begin
        if (!reset) begin
            checkOutput("inv_onehot", 32'($onehot0(gnt)), 32'd1);
            checkOutput("inv_gnt_sel", 32'(gnt), en ? 32'(4'b0001 << {sel_b, sel_a}) : 32'd0);
            checkOutput("inv_busy_en", 32'(en && !busy), 32'd0);
            if (prevEn && en)
                checkOutput("inv_sel_stable", 32'({sel_b, sel_a}), 32'(prevSel));
            if (en && !prevEn) begin
                if (expQ.size() == 0)
                    checkOutput("grant_unexpected", 32'(gnt), 32'd0);
                else
                    checkOutput("grant_order", 32'({sel_b, sel_a}), 32'(expQ.pop_front()));
            end
        end
        prevEn  = en;
        prevSel = {sel_b, sel_a};
    end

    initial begin
        int enCount;
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        tick(2);
        checkOutput("t1_reset_en", 32'(en), 32'd0);
        checkOutput("t1_reset_gnt", 32'(gnt), 32'd0);
        checkOutput("t1_reset_sel", 32'({sel_b, sel_a}), 32'd0);
        checkOutput("t1_reset_busy", 32'(busy), 32'd0);
        reset = 1'b0;
        tick(1);
        checkOutput("t1_idle_en", 32'(en), 32'd0);

        // Single request: four enable cycles, one gap, then idle.
        expQ.push_back(2);
        applyStimulus(4'b0100, 1'b0);
        for (int i = 1; i <= 6; i++) begin
            tick(1);
            checkOutput("t2_en", 32'(en), 32'(i <= 4));
            if (i == 1) begin
                checkOutput("t2_gnt", 32'(gnt), 32'b0100);
                checkOutput("t2_sel", 32'({sel_b, sel_a}), 32'd2);
            end
            if (i == 5) begin
                checkOutput("t2_gap_busy", 32'(busy), 32'd1);
                applyStimulus(4'b0000, 1'b0);
            end
            if (i == 6)
                checkOutput("t2_idle_busy", 32'(busy), 32'd0);
        end

        reset = 1'b1;
        tick(1);
        reset = 1'b0;
        tick(1);

        // All four requesting: order 0,1,2,3,0 with a six-cycle period.
        expQ.push_back(0);
        expQ.push_back(1);
        expQ.push_back(2);
        expQ.push_back(3);
        expQ.push_back(0);
        applyStimulus(4'b1111, 1'b0);
        enCount = 0;
        for (int i = 1; i <= 30; i++) begin
            tick(1);
            if (en) enCount++;
            if (i == 30) applyStimulus(4'b0000, 1'b0);
        end
        checkOutput("t3_en_cycles", 32'(enCount), 32'd20);
        tick(2);
        checkOutput("t3_end_en", 32'(en), 32'd0);
        checkOutput("t3_end_busy", 32'(busy), 32'd0);

        // Early drop of the active request, then the waiting requester is served.
        expQ.push_back(1);
        expQ.push_back(3);
        applyStimulus(4'b1010, 1'b0);
        tick(1);
        checkOutput("t4_gnt_first", 32'(gnt), 32'b0010);
        tick(1);
        checkOutput("t4_en_second", 32'(en), 32'd1);
        applyStimulus(4'b1000, 1'b0);
        tick(1);
        checkOutput("t4_early_drop_en", 32'(en), 32'd0);
        checkOutput("t4_gap_busy", 32'(busy), 32'd1);
        tick(1);
        checkOutput("t4_idle_busy", 32'(busy), 32'd0);
        tick(1);
        checkOutput("t4_gnt_next", 32'(gnt), 32'b1000);
        tick(3);
        checkOutput("t4_en_last", 32'(en), 32'd1);
        applyStimulus(4'b0000, 1'b0);
        tick(1);
        checkOutput("t4_en_after", 32'(en), 32'd0);
        tick(1);

        // Asynchronous reset during a grant; priority pointer returns to 0.
        expQ.push_back(2);
        applyStimulus(4'b0100, 1'b0);
        tick(2);
        checkOutput("t5_en_active", 32'(en), 32'd1);
        reset = 1'b1;
        applyStimulus(4'b0000, 1'b0);
        #1;
        checkOutput("t5_async_en", 32'(en), 32'd0);
        checkOutput("t5_async_gnt", 32'(gnt), 32'd0);
        checkOutput("t5_async_busy", 32'(busy), 32'd0);
        tick(1);
        reset = 1'b0;
        expQ.push_back(0);
        applyStimulus(4'b1111, 1'b0);
        tick(1);
        checkOutput("t5_first_after_reset", 32'(gnt), 32'b0001);
        tick(3);
        applyStimulus(4'b0000, 1'b0);
        tick(2);
        checkOutput("t5_end_busy", 32'(busy), 32'd0);

        // Lock held with a single requester.
`ifdef DEMUX_CTRL_LOCK_EN
        expQ.push_back(0);
`else
        expQ.push_back(0);
        expQ.push_back(0);
`endif
        applyStimulus(4'b0001, 1'b1);
        for (int i = 1; i <= 12; i++) begin
            tick(1);
`ifdef DEMUX_CTRL_LOCK_EN
            checkOutput("t6_lock_en", 32'(en), 32'd1);
`else
            checkOutput("t6_nolock_en", 32'(en), 32'(((i - 1) % 6) < 4));
`endif
            if (i == 12) applyStimulus(4'b0000, 1'b0);
        end
        tick(3);
        checkOutput("t6_end_en", 32'(en), 32'd0);
        checkOutput("t6_end_busy", 32'(busy), 32'd0);
        checkOutput("scoreboard_empty", 32'(expQ.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
